fp32_sub_seq: RTL and testbench

Multi-cycle FP32 subtractor that computes oDiff = iA − iB. It is the inverse-operation companion to the combinational FP32 adder in the Adder datapath, and uses the same field conventions: zero-exponent operands are flushed to zero, results are truncated, and there is no NaN/Inf input handling. Unlike the adder, it is sequential. It aligns and normalizes one bit per cycle behind a valid/ready handshake, trading latency for area.

---
 rtl/fp32_sub_seq.sv | 198 +++++++++++++++++++
 tb/tb_fp32_sub_seq.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/fp32_sub_seq.sv
// Multi-cycle FP32 subtractor (oDiff = iA - iB): aligns and normalizes one bit per
// cycle behind a valid/ready handshake. Zero-exponent operands flush to zero, results truncate.
module fp32_sub_seq (
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic [31:0] iA,
    input  logic [31:0] iB,
    input  logic        iValid,
    output logic        oReady,
    output logic [31:0] oDiff,
    output logic        oValid,
    input  logic        iReady
);

    localparam int unsigned DW = 32;   // FP32 word
    localparam int unsigned EW = 8;    // exponent field
    localparam int unsigned FW = 23;   // fraction field
    localparam int unsigned MW = 24;   // mantissa with hidden one
    localparam int unsigned AW = 49;   // {carry, mantissa, guard bits}
    localparam int unsigned CW = 6;    // alignment count (capped below AW)
    localparam int unsigned XW = 10;   // signed working exponent

    localparam logic signed [XW-1:0] EXP_ZERO = '0;
    localparam logic signed [XW-1:0] EXP_OVF  = XW'(255);

    typedef enum logic [2:0] {IDLE, ALIGN, OP, NORM, DONE} state_t;

    typedef struct packed {
        logic          s;
        logic [EW-1:0] e;
        logic [FW-1:0] f;
    } fp32_t;

    state_t                 state_q, state_n;
    logic [AW-1:0]          lg_q, lg_n;
    logic [AW-1:0]          sm_q, sm_n;
    logic [CW-1:0]          cnt_q, cnt_n;
    logic signed [XW-1:0]   ew_q, ew_n;
    logic                   sl_q, sl_n;
    logic                   ss_q, ss_n;
    logic                   byp_q, byp_n;
    logic [DW-1:0]          res_q, res_n;
    logic [DW-1:0]          diff_n;
    logic                   valid_n;
    logic                   ready_n;

    fp32_t                  op_a, op_b;
    logic [MW-1:0]          a_m, b_m, l_m, s_m;
    logic [EW-1:0]          l_e, s_e, e_diff;
    logic                   l_sign, s_sign, a_big;
    logic                   is_zero;
    logic [DW-1:0]          zero_res;
    logic [DW-1:0]          packed_res;

    // Operand decode: B is captured with its sign inverted, then ordered by magnitude.
    always_comb begin
        op_a   = fp32_t'(iA);
        op_b   = fp32_t'({~iB[DW-1], iB[DW-2:0]});
        a_m    = {1'b1, op_a.f};
        b_m    = {1'b1, op_b.f};
        a_big  = (op_a.e > op_b.e) || ((op_a.e == op_b.e) && (a_m > b_m));
        if (a_big) begin
            l_e = op_a.e; l_m = a_m; l_sign = op_a.s;
            s_e = op_b.e; s_m = b_m; s_sign = op_b.s;
        end else begin
            l_e = op_b.e; l_m = b_m; l_sign = op_b.s;
            s_e = op_a.e; s_m = a_m; s_sign = op_a.s;
        end
        e_diff = l_e - s_e;

        is_zero = (op_a.e == '0) || (op_b.e == '0);
        if ((op_a.e == '0) && (op_b.e == '0)) begin
            zero_res = '0;
        end else if (op_a.e == '0) begin
            zero_res = DW'(op_b);
        end else begin
            zero_res = iA;
        end
    end

    // Result packing with underflow flush and overflow saturation to infinity.
    always_comb begin
        if (ew_q <= EXP_ZERO) begin
            packed_res = '0;
        end else if (ew_q >= EXP_OVF) begin
            packed_res = {sl_q, {EW{1'b1}}, {FW{1'b0}}};
        end else begin
            packed_res = {sl_q, ew_q[EW-1:0], lg_q[AW-2 -: FW]};
        end
    end

    // Next-state and datapath updates.
    always_comb begin
        state_n = state_q;
        lg_n    = lg_q;
        sm_n    = sm_q;
        cnt_n   = cnt_q;
        ew_n    = ew_q;
        sl_n    = sl_q;
        ss_n    = ss_q;
        byp_n   = byp_q;
        res_n   = res_q;
        diff_n  = oDiff;

        unique case (state_q)
            IDLE: begin
                if (iValid && oReady) begin
                    sl_n  = l_sign;
                    ss_n  = s_sign;
                    lg_n  = {1'b0, l_m, {MW{1'b0}}};
                    ew_n  = XW'(l_e) + XW'(1);
                    res_n = zero_res;
                    byp_n = is_zero;
                    if (e_diff >= EW'(AW)) begin
                        sm_n  = '0;
                        cnt_n = '0;
                    end else begin
                        sm_n  = {1'b0, s_m, {MW{1'b0}}};
                        cnt_n = CW'(e_diff);
                    end
                    state_n = is_zero ? OP : ALIGN;
                end
            end
            ALIGN: begin
                if (cnt_q != '0) begin
                    sm_n  = sm_q >> 1;
                    cnt_n = cnt_q - CW'(1);
                end
                if (cnt_q <= CW'(1)) begin
                    state_n = OP;
                end
            end
            OP: begin
                // Zero-operand results are staged here so they appear one cycle after accept.
                if (byp_q) begin
                    diff_n  = res_q;
                    state_n = DONE;
                end else begin
                    lg_n    = (sl_q != ss_q) ? (lg_q - sm_q) : (lg_q + sm_q);
                    state_n = NORM;
                end
            end
            NORM: begin
                if (lg_q == '0) begin
                    diff_n  = '0;
                    state_n = DONE;
                end else if (lg_q[AW-1]) begin
                    diff_n  = packed_res;
                    state_n = DONE;
                end else begin
                    lg_n = lg_q << 1;
                    ew_n = ew_q - XW'(1);
                end
            end
            DONE: begin
                if (iReady) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        valid_n = (state_n == DONE);
        ready_n = (state_n == IDLE);
    end

    // State, datapath and registered outputs.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q <= IDLE;
            lg_q    <= '0;
            sm_q    <= '0;
            cnt_q   <= '0;
            ew_q    <= '0;
            sl_q    <= 1'b0;
            ss_q    <= 1'b0;
            byp_q   <= 1'b0;
            res_q   <= '0;
            oDiff   <= '0;
            oValid  <= 1'b0;
            oReady  <= 1'b1;
        end else begin
            state_q <= state_n;
            lg_q    <= lg_n;
            sm_q    <= sm_n;
            cnt_q   <= cnt_n;
            ew_q    <= ew_n;
            sl_q    <= sl_n;
            ss_q    <= ss_n;
            byp_q   <= byp_n;
            res_q   <= res_n;
            oDiff   <= diff_n;
            oValid  <= valid_n;
            oReady  <= ready_n;
        end
    end

endmodule

// File: tb/tb_fp32_sub_seq.sv
// Directed and randomized checks for fp32_sub_seq using an expected-result queue.
module tb_fp32_sub_seq;

    logic        iCLK;
    logic        iRST_N;
    logic [31:0] iA;
    logic [31:0] iB;
    logic        iValid;
    logic        oReady;
    logic [31:0] oDiff;
    logic        oValid;
    logic        iReady;

    int          n_vec  = 0;
    int          n_miss = 0;
    logic [31:0] q_diff[$];
    int          q_lat[$];
    logic [31:0] last_exp;

    fp32_sub_seq dut (
        .iCLK   (iCLK),
        .iRST_N (iRST_N),
        .iA     (iA),
        .iB     (iB),
        .iValid (iValid),
        .oReady (oReady),
        .oDiff  (oDiff),
        .oValid (oValid),
        .iReady (iReady)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Reference: aligned magnitudes, leading-one search, truncate, clamp exponent.
    task automatic model(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] d, output int lat);
        logic [7:0]  ae, be, le, se;
        logic [23:0] am, bm, lm, sm;
        logic        ls, ss;
        logic [63:0] lv, sv, sum, nv;
        int          dd, z, e, p;
        ae = a[30:23]; be = b[30:23];
        am = {1'b1, a[22:0]}; bm = {1'b1, b[22:0]};
        lat = 1;
        d   = 32'h0;
        if (ae == 8'd0 && be == 8'd0) d = 32'h0;
        else if (ae == 8'd0)          d = {~b[31], b[30:0]};
        else if (be == 8'd0)          d = a;
        else begin
            if (ae > be || (ae == be && am > bm)) begin
                le = ae; lm = am; ls = a[31];  se = be; sm = bm; ss = ~b[31];
            end else begin
                le = be; lm = bm; ls = ~b[31]; se = ae; sm = am; ss = a[31];
            end
            dd  = int'(le) - int'(se);
            lv  = 64'(lm) << 24;
            sv  = (dd >= 49) ? 64'd0 : ((64'(sm) << 24) >> dd);
            sum = (ls != ss) ? (lv - sv) : (lv + sv);
            z   = 0;
            if (sum == 64'd0) d = 32'h0;
            else begin
                p = 0;
                for (int i = 0; i < 49; i++) if (sum[i]) p = i;
                z  = 48 - p;
                nv = sum << z;
                e  = int'(le) + 1 - z;
                if (e <= 0)        d = 32'h0;
                else if (e >= 255) d = {ls, 8'hFF, 23'd0};
                else               d = {ls, 8'(e), nv[47:25]};
            end
            lat = ((dd >= 49) ? 1 : ((dd < 1) ? 1 : dd)) + 1 + z + 1;
        end
    endtask

    task automatic run(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] expd, input int hold);
        logic [31:0] md, ed;
        int          ml, el, n;
        model(a, b, md, ml);
        q_diff.push_back(expd);
        q_lat.push_back(ml);
        iReady = (hold == 0);
        @(negedge iCLK);
        check("ready_idle", 32'(oReady), 32'd1);
        iA = a; iB = b; iValid = 1'b1;
        @(posedge iCLK); #1;
        iValid = 1'b0;
        iA = $urandom; iB = $urandom;
        check("ready_busy", 32'(oReady), 32'd0);
        check("diff_hold_prev", oDiff, last_exp);
        n = 0;
        while (!oValid && n < 200) begin
            @(posedge iCLK); #1;
            n++;
        end
        ed = q_diff.pop_front();
        el = q_lat.pop_front();
        check("latency", 32'(n), 32'(el));
        check("diff", oDiff, ed);
        for (int k = 0; k < hold; k++) begin
            @(posedge iCLK); #1;
            check("bp_valid", 32'(oValid), 32'd1);
            check("bp_diff", oDiff, ed);
            check("bp_ready", 32'(oReady), 32'd0);
        end
        iReady = 1'b1;
        @(posedge iCLK); #1;
        check("valid_drop", 32'(oValid), 32'd0);
        check("ready_back", 32'(oReady), 32'd1);
        check("diff_keep", oDiff, ed);
        last_exp = ed;
    endtask

    task automatic run_model(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] md;
        int          ml;
        model(a, b, md, ml);
        run(a, b, md, 0);
    endtask

    initial begin
        logic [31:0] ra, rb;
        iRST_N = 1'b0; iA = '0; iB = '0; iValid = 1'b0; iReady = 1'b1;
        last_exp = 32'h0;
        repeat (2) @(posedge iCLK);
        #1;
        check("rst_valid", 32'(oValid), 32'd0);
        check("rst_diff",  oDiff, 32'h0);
        check("rst_ready", 32'(oReady), 32'd1);
        @(negedge iCLK);
        iRST_N = 1'b1;

        run(32'h40400000, 32'h3F800000, 32'h40000000, 0);
        run(32'h3F800000, 32'h3F800000, 32'h00000000, 0);
        run(32'h3F800000, 32'hBF800000, 32'h40000000, 0);
        run(32'h4B800000, 32'h3F800000, 32'h4B7FFFFF, 0);
        run(32'h00000000, 32'h3F800000, 32'hBF800000, 0);
        run(32'h7F000000, 32'h3F800000, 32'h7F000000, 0);
        run(32'h3F800000, 32'h40400000, 32'hC0000000, 0);
        run(32'h3F800000, 32'h00000000, 32'h3F800000, 0);
        run(32'h00000005, 32'h80000007, 32'h00000000, 0);
        run(32'h7F800000, 32'hFF800000, 32'h7F800000, 0);
        run(32'h00800001, 32'h00800000, 32'h00000000, 0);
        run(32'h3F800000, 32'h3F000000, 32'h3F000000, 5);

        // Reset during ALIGN discards the operation immediately.
        @(negedge iCLK);
        iA = 32'h4B800000; iB = 32'h3F800000; iValid = 1'b1;
        @(posedge iCLK); #1;
        iValid = 1'b0;
        repeat (3) @(posedge iCLK);
        #1;
        iRST_N = 1'b0;
        #1;
        check("midrst_valid", 32'(oValid), 32'd0);
        check("midrst_diff",  oDiff, 32'h0);
        check("midrst_ready", 32'(oReady), 32'd1);
        @(negedge iCLK);
        iRST_N = 1'b1;
        last_exp = 32'h0;
        run(32'h40400000, 32'h3F800000, 32'h40000000, 0);

        for (int i = 0; i < 24; i++) begin
            ra = {1'(($urandom)), 8'(110 + $urandom_range(0, 30)), 23'($urandom)};
            if (i % 3 == 0)
                rb = {1'(($urandom)), ra[30:23], ra[22:8], 8'($urandom)};
            else
                rb = {1'(($urandom)), 8'(110 + $urandom_range(0, 30)), 23'($urandom)};
            run_model(ra, rb);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
